// File: rtl/megarom_flash_sequencer.sv
// Flash command sequencer for the MegaROM board: turns read/program/erase/release
// requests into 32-bit SPI frames for the CPLD bridge, with JEDEC unlock and data polling.
module megarom_flash_sequencer #(
    parameter int SCK_DIV    = 2,
    parameter int POLL_LIMIT = 65535
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [18:0] cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_error,
    output logic        busy,
    output logic        spi_SCK,
    output logic        spi_SS,
    output logic        spi_MOSI,
    input  logic        spi_MISO
);
    localparam logic [1:0]  OP_PROG   = 2'b01;
    localparam logic [1:0]  OP_ERASE  = 2'b10;
    localparam logic [1:0]  OP_REL    = 2'b11;
    localparam logic [7:0]  DIV_LAST  = 8'(SCK_DIV - 1);
    localparam logic [15:0] POLL_LAST = 16'(POLL_LIMIT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, GAP, SHIFT, EVAL, DONE} state_t;
    state_t state, state_next;

    logic [7:0]  div, div_next;
    logic        half, half_next;
    logic [4:0]  bit_idx, bit_next;
    logic [2:0]  step, step_next;
    logic [15:0] poll_cnt, poll_next;
    logic        link_fault, fault_next;
    logic        accept, sample, poll_hit, poll_end, is_poll;
    logic [2:0]  unlock_n;
    logic [7:0]  target;
    logic [1:0]  op;
    logic [18:0] addr;
    logic [7:0]  data;
    logic [31:0] frame;
    logic [7:0]  rx;

    function automatic logic [31:0] wr_frame(input logic [18:0] a, input logic [7:0] d);
        return {4'h0, d, 1'b0, a};
    endfunction

    function automatic logic [31:0] rd_frame(input logic [18:0] a);
        return {12'h000, 1'b1, a};
    endfunction

    // Frames at steps past the unlock sequence are poll reads at the command address.
    function automatic logic [31:0] select_frame(input logic [1:0] o, input logic [2:0] s,
                                                 input logic [18:0] a, input logic [7:0] d);
        logic [31:0] f;
        f = rd_frame(a);
        if (o == OP_REL) begin
            f = 32'hFFFF_FFFF;
        end else if (o == OP_PROG) begin
            case (s)
                3'd0:    f = wr_frame(19'h05555, 8'hAA);
                3'd1:    f = wr_frame(19'h02AAA, 8'h55);
                3'd2:    f = wr_frame(19'h05555, 8'hA0);
                3'd3:    f = wr_frame(a, d);
                default: f = rd_frame(a);
            endcase
        end else if (o == OP_ERASE) begin
            case (s)
                3'd0:    f = wr_frame(19'h05555, 8'hAA);
                3'd1:    f = wr_frame(19'h02AAA, 8'h55);
                3'd2:    f = wr_frame(19'h05555, 8'h80);
                3'd3:    f = wr_frame(19'h05555, 8'hAA);
                3'd4:    f = wr_frame(19'h02AAA, 8'h55);
                3'd5:    f = wr_frame({a[18:12], 12'h000}, 8'h30);
                default: f = rd_frame(a);
            endcase
        end
        return f;
    endfunction

    assign cmd_ready = (state == IDLE) || (state == DONE);
    assign busy      = ~cmd_ready;
    assign rsp_valid = (state == DONE);
    assign accept    = cmd_valid && cmd_ready;
    assign sample    = (state == SHIFT) && !half && (div == DIV_LAST);
    assign poll_hit  = (rx == target);
    assign poll_end  = !is_poll || poll_hit || link_fault || (poll_cnt == POLL_LAST);

    always_comb begin
        unlock_n = 3'd0;
        is_poll  = 1'b0;
        target   = 8'hFF;
        case (op)
            OP_PROG:  begin unlock_n = 3'd4; is_poll = 1'b1; target = data; end
            OP_ERASE: begin unlock_n = 3'd6; is_poll = 1'b1; end
            default:  ;
        endcase
    end

    always_comb begin
        state_next = state;
        div_next   = div;
        half_next  = half;
        bit_next   = bit_idx;
        step_next  = step;
        poll_next  = poll_cnt;
        fault_next = link_fault;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (accept) begin
                    state_next = LOAD;
                    step_next  = 3'd0;
                    poll_next  = 16'd0;
                    fault_next = 1'b0;
                end
            end
            LOAD: begin
                state_next = GAP;
                div_next   = 8'd0;
                half_next  = 1'b0;
                bit_next   = 5'd0;
            end
            GAP: begin
                if (div == DIV_LAST) begin
                    div_next  = 8'd0;
                    half_next = ~half;
                    if (half) state_next = SHIFT;
                end else begin
                    div_next = div + 8'd1;
                end
            end
            SHIFT: begin
                if (div == DIV_LAST) begin
                    div_next  = 8'd0;
                    half_next = ~half;
                    if (half) begin
                        if (bit_idx == 5'd31) state_next = EVAL;
                        else                  bit_next   = bit_idx + 5'd1;
                    end
                end else begin
                    div_next = div + 8'd1;
                end
                // Bridge echoes an alternating pattern on bits 1-18; anything else is a broken link.
                if (sample && (bit_idx >= 5'd1) && (bit_idx <= 5'd18) && (spi_MISO != bit_idx[0]))
                    fault_next = 1'b1;
            end
            EVAL: begin
                if (step < unlock_n) begin
                    step_next  = step + 3'd1;
                    state_next = LOAD;
                end else begin
                    if (is_poll) poll_next = poll_cnt + 16'd1;
                    state_next = poll_end ? DONE : LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state      <= IDLE;
            div        <= 8'd0;
            half       <= 1'b0;
            bit_idx    <= 5'd0;
            step       <= 3'd0;
            poll_cnt   <= 16'd0;
            link_fault <= 1'b0;
            rsp_data   <= 8'h00;
            rsp_error  <= 1'b0;
            spi_SCK    <= 1'b0;
            spi_SS     <= 1'b1;
            spi_MOSI   <= 1'b0;
        end else begin
            state      <= state_next;
            div        <= div_next;
            half       <= half_next;
            bit_idx    <= bit_next;
            step       <= step_next;
            poll_cnt   <= poll_next;
            link_fault <= fault_next;
            if (state == EVAL && state_next == DONE) begin
                rsp_data  <= rx;
                rsp_error <= link_fault | (is_poll & ~poll_hit);
            end
            // SPI pins are registered images of the next state so they never glitch.
            spi_SCK  <= ((state_next == GAP) && !half_next) || ((state_next == SHIFT) && half_next);
            spi_SS   <= (state_next == GAP) || (state_next == IDLE) || (state_next == DONE);
            spi_MOSI <= (state_next == SHIFT) ? frame[5'd31 - bit_next] : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op   <= cmd_op;
            addr <= cmd_addr;
            data <= cmd_data;
        end
        if (state == LOAD) frame <= select_frame(op, step, addr, data);
        if (sample && (bit_idx >= 5'd24)) rx <= {rx[6:0], spi_MISO};
    end
endmodule

// File: tb/tb_megarom_flash_sequencer.sv
// Randomized bench for megarom_flash_sequencer: a bridge model answers frames, and a
// command-level model predicts frames, response values and completion time.
module tb_megarom_flash_sequencer;
    localparam int SCK_DIV    = 2;
    localparam int POLL_LIMIT = 4;
    localparam int LAT_FRAME  = 66 * SCK_DIV + 2;

    logic        clk;
    logic        nRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [18:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_error;
    logic        busy;
    logic        spi_SCK, spi_SS, spi_MOSI, spi_MISO;

    megarom_flash_sequencer #(.SCK_DIV(SCK_DIV), .POLL_LIMIT(POLL_LIMIT)) dut (
        .clk(clk), .nRESET(nRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_error(rsp_error), .busy(busy), .spi_SCK(spi_SCK),
        .spi_SS(spi_SS), .spi_MOSI(spi_MOSI), .spi_MISO(spi_MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // bridge configuration, owned by the driver
    int         brg_mf;
    logic [7:0] brg_mv, brg_ov;
    bit         brg_stuck;
    int         cmd_base;

    // bridge state, owned by the bridge process
    int          brg_cnt = 0;
    int          nframes = 0;
    logic        prev_sck = 1'b0;
    logic [31:0] shreg = 32'h0;
    logic [7:0]  cur_byte;
    logic [31:0] frames[$];

    // expectations
    logic [31:0] exp_frames[$];
    logic [7:0]  exp_data, held_data;
    logic        exp_err, held_err;
    int          acc_cyc = 0;
    int          exp_done = -1;
    bit          chk_en = 0;
    logic [7:0]  last_data;
    logic        last_err;
    int          rv_cyc = 0;

    function automatic logic [7:0] val_for(input int k);
        return (brg_mf != 0 && k >= brg_mf) ? brg_mv : brg_ov;
    endfunction

    function automatic logic [31:0] wr_f(input logic [18:0] a, input logic [7:0] d);
        return {4'h0, d, 1'b0, a};
    endfunction

    function automatic logic [31:0] rd_f(input logic [18:0] a);
        return {12'h000, 1'b1, a};
    endfunction

    // Bridge: counts SCK rises after SS falls, shifts MOSI in, answers on MISO.
    always @(negedge clk) begin
        if (spi_SS) begin
            brg_cnt = 0;
        end else if (spi_SCK && !prev_sck) begin
            shreg = {shreg[30:0], spi_MOSI};
            brg_cnt++;
            if (brg_cnt == 32) begin
                frames.push_back(shreg);
                nframes++;
            end
        end
        cur_byte = val_for(nframes - cmd_base + 1);
        if (brg_stuck)                          spi_MISO = 1'b0;
        else if (brg_cnt >= 1 && brg_cnt <= 18) spi_MISO = brg_cnt[0];
        else if (brg_cnt >= 24 && brg_cnt <= 31) spi_MISO = cur_byte[31 - brg_cnt];
        else                                    spi_MISO = 1'b0;
        prev_sck = spi_SCK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic compare_cycle();
        bit want_busy, at_done;
        if (!chk_en) return;
        at_done   = (exp_done >= 0) && (cyc == exp_done);
        want_busy = (exp_done >= 0) && (cyc >= acc_cyc) && (cyc < exp_done);
        chk("busy", busy, want_busy);
        chk("cmd_ready", cmd_ready, !want_busy);
        chk("rsp_valid", rsp_valid, at_done);
        if (rsp_valid) begin
            last_data = rsp_data;
            last_err  = rsp_error;
            rv_cyc    = cyc;
        end
        if (at_done) begin
            chk("rsp_data", rsp_data, exp_data);
            chk("rsp_error", rsp_error, exp_err);
            chk("frame_count", nframes - cmd_base, exp_frames.size());
            for (int i = 0; i < exp_frames.size(); i++)
                chk("frame", frames[cmd_base + i], exp_frames[i]);
            held_data = exp_data;
            held_err  = exp_err;
        end else begin
            chk("rsp_data_hold", rsp_data, held_data);
            chk("rsp_error_hold", rsp_error, held_err);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic build_model(input logic [1:0] op, input logic [18:0] a, input logic [7:0] d);
        logic [7:0] tgt, v;
        exp_frames.delete();
        v = 8'h00;
        if (op == 2'b00 || op == 2'b11) begin
            exp_frames.push_back(op == 2'b00 ? rd_f(a) : 32'hFFFF_FFFF);
            exp_data = brg_stuck ? 8'h00 : val_for(1);
            exp_err  = brg_stuck;
        end else begin
            exp_frames.push_back(wr_f(19'h05555, 8'hAA));
            exp_frames.push_back(wr_f(19'h02AAA, 8'h55));
            if (op == 2'b01) begin
                exp_frames.push_back(wr_f(19'h05555, 8'hA0));
                exp_frames.push_back(wr_f(a, d));
                tgt = d;
            end else begin
                exp_frames.push_back(wr_f(19'h05555, 8'h80));
                exp_frames.push_back(wr_f(19'h05555, 8'hAA));
                exp_frames.push_back(wr_f(19'h02AAA, 8'h55));
                exp_frames.push_back(wr_f({a[18:12], 12'h000}, 8'h30));
                tgt = 8'hFF;
            end
            for (int p = 1; p <= POLL_LIMIT; p++) begin
                exp_frames.push_back(rd_f(a));
                v = brg_stuck ? 8'h00 : val_for(exp_frames.size());
                if (brg_stuck || v == tgt) break;
            end
            exp_data = v;
            exp_err  = brg_stuck || (v != tgt);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [18:0] a, input logic [7:0] d,
                           input int mf, input logic [7:0] mv, input logic [7:0] ov, input bit stuck);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 3000) begin
            tick();
            guard++;
        end
        if (!cmd_ready) chk("cmd_ready_wait", cmd_ready, 1);
        brg_mf = mf; brg_mv = mv; brg_ov = ov; brg_stuck = stuck;
        cmd_base = nframes;
        build_model(op, a, d);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        acc_cyc  = cyc + 1;
        exp_done = acc_cyc + exp_frames.size() * LAT_FRAME;
        tick();
        cmd_valid = 1'b0;
        while (cyc <= exp_done) begin
            // requests while busy must be ignored
            if (cyc < exp_done - 3) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 2'($urandom);
                cmd_addr  = 19'($urandom);
                cmd_data  = 8'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int guard;
        logic [1:0]  r_op;
        logic [18:0] r_a;
        logic [7:0]  r_d, r_mv;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 19'h0; cmd_data = 8'h0;
        brg_mf = 0; brg_mv = 8'h00; brg_ov = 8'h00; brg_stuck = 1'b0; cmd_base = 0;
        held_data = 8'h00; held_err = 1'b0;
        nRESET = 1'b1;
        #2 nRESET = 1'b0;
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_ss", spi_SS, 1);
        chk("rst_sck", spi_SCK, 0);
        chk("rst_mosi", spi_MOSI, 0);
        nRESET = 1'b1;
        chk_en = 1'b1;
        tick();

        // read of 12345 returning 5A
        run_cmd(2'b00, 19'h12345, 8'h00, 1, 8'h5A, 8'h5A, 0);
        chk("read_frame", frames[cmd_base], 32'h0009_2345);
        chk("read_data", last_data, 8'h5A);
        chk("read_latency", rv_cyc - acc_cyc, 134);

        // program 00010=C3, match on the third poll
        run_cmd(2'b01, 19'h00010, 8'hC3, 7, 8'hC3, 8'h00, 0);
        chk("prog_frames", nframes - cmd_base, 7);
        chk("prog_f0", frames[cmd_base + 0], 32'h0AA0_5555);
        chk("prog_f1", frames[cmd_base + 1], 32'h0550_2AAA);
        chk("prog_f2", frames[cmd_base + 2], 32'h0A00_5555);
        chk("prog_f3", frames[cmd_base + 3], 32'h0C30_0010);
        chk("prog_poll", frames[cmd_base + 4], 32'h0008_0010);
        chk("prog_data", last_data, 8'hC3);

        // erase at 1F234, FF on the second poll
        run_cmd(2'b10, 19'h1F234, 8'h00, 8, 8'hFF, 8'h12, 0);
        chk("erase_frames", nframes - cmd_base, 8);
        chk("erase_f5", frames[cmd_base + 5], 32'h0301_F000);
        chk("erase_err", last_err, 0);

        // program never matching -> timeout after POLL_LIMIT polls
        run_cmd(2'b01, 19'h0ABCD, 8'h77, 0, 8'h00, 8'h3C, 0);
        chk("tmo_frames", nframes - cmd_base, 8);
        chk("tmo_err", last_err, 1);
        chk("tmo_data", last_data, 8'h3C);

        // MISO stuck low during a read
        run_cmd(2'b00, 19'h00123, 8'h00, 1, 8'hA5, 8'hA5, 1);
        chk("stuck_err", last_err, 1);

        // release
        run_cmd(2'b11, 19'h00000, 8'h00, 1, 8'h96, 8'h96, 0);
        chk("release_frame", frames[cmd_base], 32'hFFFF_FFFF);

        // reset in the middle of the first (write) frame of a program
        chk_en = 1'b0;
        brg_mf = 0; brg_ov = 8'h00; brg_stuck = 1'b0; cmd_base = nframes;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 19'h00400; cmd_data = 8'h11;
        tick();
        cmd_valid = 1'b0;
        guard = 0;
        while (brg_cnt != 10 && guard < 1000) begin
            tick();
            guard++;
        end
        chk("midframe_bit", brg_cnt, 10);
        @(posedge clk);
        #1;
        chk("pre_rst_ss", spi_SS, 0);
        nRESET = 1'b0;
        #1;
        chk("midrst_ss", spi_SS, 1);
        chk("midrst_sck", spi_SCK, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_ready, 1);
        repeat (3) tick();
        nRESET = 1'b1;
        exp_done = -1; held_data = 8'h00; held_err = 1'b0;
        chk_en = 1'b1;
        tick();
        run_cmd(2'b00, 19'h54321, 8'h00, 1, 8'hE7, 8'hE7, 0);
        chk("post_rst_read", last_data, 8'hE7);

        // randomized commands
        for (int n = 0; n < 20; n++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = 19'($urandom);
            r_d  = 8'($urandom);
            r_mv = (r_op == 2'b10) ? 8'hFF : (r_op == 2'b01) ? r_d : 8'($urandom);
            run_cmd(r_op, r_a, r_d, $urandom_range(0, 12), r_mv, 8'($urandom),
                    ($urandom_range(0, 9) == 0));
        end

        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
